fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID register of the pipelined CPU: the producer end of the op/funct

---
 rtl/fetch_stage_pkg.sv | 33 +++
 rtl/fetch_stage_if.sv | 14 +
 rtl/fetch_stage_if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: opcode/funct slices, FSM state codes, IF/ID record.
// No logic; imported by the fetch stage, its IF/ID register and the bench.
package fetch_stage_pkg;

    typedef logic [5:0] OPECODE;
    typedef logic [5:0] FUNCT;

    typedef logic [1:0] FETCH_STATE;
    localparam FETCH_STATE S_REQ  = 2'd0;
    localparam FETCH_STATE S_WAIT = 2'd1;
    localparam FETCH_STATE S_HOLD = 2'd2;
    localparam FETCH_STATE S_DROP = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } IF_ID_T;

    // A bubble decodes as op=0/funct=0, i.e. the sll nop.
    localparam IF_ID_T IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

    function automatic OPECODE op_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic FUNCT funct_of(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: req/gnt handshake with a separate rvalid data return.
// The fetch side is the master; at most one request is outstanding.
interface fetch_stage_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: one cycle load; stall holds, flush/redirect forces a bubble.
// Priority reset > flush > stall > load > bubble.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_load,
    input  logic   i_stall,
    input  logic   i_flush,
    input  IF_ID_T i_dat,
    output IF_ID_T o_dat
);

    IF_ID_T r_dat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dat <= IF_ID_BUBBLE;
        end else if (i_flush) begin
            r_dat <= IF_ID_BUBBLE;
        end else if (i_stall) begin
            r_dat <= r_dat;
        end else if (i_load) begin
            r_dat <= i_dat;
        end else begin
            r_dat <= IF_ID_BUBBLE;
        end
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, one-outstanding imem fetch FSM, one-word hold buffer, IF/ID register.
// Min 2 cycles request->IF/ID; a decode stall parks the returning word and stops requesting.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_pc_src,
    input  logic [31:0]          i_pc_branch,
    input  logic                 i_jmp,
    input  logic [31:0]          i_pc_jmp,
    input  logic                 i_stall_d,
    input  logic                 i_flush_d,
    fetch_stage_if.master        io_imem,
    output logic [31:0]          o_pc_f,
    output logic [31:0]          o_instr_d,
    output OPECODE               o_op_d,
    output FUNCT                 o_funct_d,
    output logic [31:0]          o_pc_plus4_d,
    output logic                 o_valid_d
);

    FETCH_STATE  r_state;
    FETCH_STATE  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_redirect;
    IF_ID_T      r_buf;
    IF_ID_T      w_buf_nxt;
    logic        w_load;
    IF_ID_T      w_load_dat;
    IF_ID_T      w_if_id;
    IF_ID_T      w_fetched;

    assign w_redirect = i_pc_src | i_jmp;
    assign w_target   = i_jmp ? i_pc_jmp : i_pc_branch;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_fetched  = '{instr: io_imem.rdata, pc_plus4: w_pc_plus4, valid: 1'b1};

    assign io_imem.req  = (r_state == S_REQ);
    assign io_imem.addr = r_pc;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_buf_nxt   = r_buf;
        w_load      = 1'b0;
        w_load_dat  = w_fetched;

        if (w_redirect) begin
            w_pc_nxt  = w_target;
            w_buf_nxt = IF_ID_BUBBLE;
            // A granted-but-unreturned request must still be drained before refetching.
            case (r_state)
                S_REQ:   w_state_nxt = io_imem.gnt    ? S_DROP : S_REQ;
                S_WAIT:  w_state_nxt = io_imem.rvalid ? S_REQ  : S_DROP;
                S_DROP:  w_state_nxt = io_imem.rvalid ? S_REQ  : S_DROP;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (io_imem.gnt) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (io_imem.rvalid) begin
                        if (i_stall_d) begin
                            w_buf_nxt   = w_fetched;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_load      = 1'b1;
                            w_pc_nxt    = w_pc_plus4;
                            w_state_nxt = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!i_stall_d) begin
                        w_load      = 1'b1;
                        w_load_dat  = r_buf;
                        w_pc_nxt    = w_pc_plus4;
                        w_buf_nxt   = IF_ID_BUBBLE;
                        w_state_nxt = S_REQ;
                    end
                end
                default: begin
                    if (io_imem.rvalid) begin
                        w_state_nxt = S_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_buf   <= IF_ID_BUBBLE;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    fetch_stage_if_id_reg u_if_id (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_stall (i_stall_d),
        .i_flush (i_flush_d | w_redirect),
        .i_dat   (w_load_dat),
        .o_dat   (w_if_id)
    );

    assign o_pc_f       = r_pc;
    assign o_instr_d    = w_if_id.instr;
    assign o_op_d       = op_of(w_if_id.instr);
    assign o_funct_d    = funct_of(w_if_id.instr);
    assign o_pc_plus4_d = w_if_id.pc_plus4;
    assign o_valid_d    = w_if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Random bench for fetch_stage: program-order queue of expected words plus a
// one-outstanding imem responder with random grant and return latency.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          N_CYCLES = 4000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        jmp;
    logic [31:0] pc_jmp;
    logic        stall_d;
    logic        flush_d;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    OPECODE      op_d;
    FUNCT        funct_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    fetch_stage_if imem_if ();

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_pc_src     (pc_src),
        .i_pc_branch  (pc_branch),
        .i_jmp        (jmp),
        .i_pc_jmp     (pc_jmp),
        .i_stall_d    (stall_d),
        .i_flush_d    (flush_d),
        .io_imem      (imem_if),
        .o_pc_f       (pc_f),
        .o_instr_d    (instr_d),
        .o_op_d       (op_d),
        .o_funct_d    (funct_d),
        .o_pc_plus4_d (pc_plus4_d),
        .o_valid_d    (valid_d)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_deliv  = 0;

    // Instruction memory contents: an address hash, so any misdirected fetch shows up.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus, imem responder and expected-stream maintenance.
    initial begin
        logic [31:0] push_pc;
        logic        pend;
        logic [31:0] pend_addr;
        int          pend_cnt;
        logic [31:0] tgt [4];

        tgt[0] = 32'h0000_0040;
        tgt[1] = 32'h0000_0080;
        tgt[2] = 32'hFFFF_FFF4;
        tgt[3] = 32'h0000_1002;
        reset = 1'b1; pc_src = 1'b0; jmp = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_branch = 32'h0; pc_jmp = 32'h0;
        imem_if.gnt = 1'b0; imem_if.rvalid = 1'b0; imem_if.rdata = 32'h0;
        push_pc = RESET_PC; pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            // Whatever was in flight at a reset or redirect edge never reaches decode.
            if (reset) begin
                exp_q.delete();
                push_pc = RESET_PC;
            end else if (pc_src || jmp) begin
                exp_q.delete();
                push_pc = jmp ? pc_jmp : pc_branch;
            end
            #1;
            while (exp_q.size() < 4) begin
                exp_q.push_back('{pc: push_pc, instr: mem_word(push_pc)});
                push_pc = push_pc + 32'd4;
            end

            imem_if.rvalid = 1'b0;
            imem_if.rdata  = $urandom;
            if (pend) begin
                if (pend_cnt == 0) begin
                    imem_if.rvalid = 1'b1;
                    imem_if.rdata  = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            imem_if.gnt = 1'b0;
            if (imem_if.req && !pend && !imem_if.rvalid && ($urandom_range(3) != 0)) begin
                imem_if.gnt = 1'b1;
                pend        = 1'b1;
                pend_addr   = imem_if.addr;
                pend_cnt    = $urandom_range(2);
            end

            reset     = (cyc < 3) || ($urandom_range(199) == 0);
            stall_d   = ($urandom_range(9) < 3);
            flush_d   = stall_d && ($urandom_range(7) == 0);
            pc_src    = ($urandom_range(24) == 0);
            jmp       = ($urandom_range(39) == 0);
            pc_branch = tgt[$urandom_range(3)];
            pc_jmp    = tgt[$urandom_range(3)];
        end

        reset = 1'b0; pc_src = 1'b0; jmp = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        repeat (2) @(posedge clk);
        n_checks++;
        if (n_deliv < 200) begin
            n_errors++;
            $display("FAIL progress: got %0d delivered words expected at least 200", n_deliv);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Monitor: classify each edge by the controls applied at it, then check IF/ID and PC.
    initial begin
        logic        c_rst;
        logic        c_sq;
        logic        c_stall;
        logic [31:0] p_instr;
        logic [31:0] p_pc4;
        logic        p_vld;
        exp_t        e;

        p_instr = 32'h0; p_pc4 = 32'h0; p_vld = 1'b0;
        forever begin
            @(posedge clk);
            c_rst   = reset;
            c_sq    = pc_src | jmp | flush_d;
            c_stall = stall_d;
            @(negedge clk);
            if (c_rst) begin
                check("reset_valid", {31'd0, valid_d}, 32'd0);
                check("reset_instr", instr_d, NOP_INSTR);
                check("reset_pc4", pc_plus4_d, 32'd0);
            end else if (c_sq) begin
                check("squash_valid", {31'd0, valid_d}, 32'd0);
                check("squash_instr", instr_d, NOP_INSTR);
                check("squash_op_funct", {20'd0, op_d, funct_d}, 32'd0);
            end else if (c_stall) begin
                check("stall_instr", instr_d, p_instr);
                check("stall_pc4", pc_plus4_d, p_pc4);
                check("stall_valid", {31'd0, valid_d}, {31'd0, p_vld});
            end else if (valid_d) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_word: got %h expected no delivery", instr_d);
                end else begin
                    e = exp_q.pop_front();
                    n_deliv++;
                    check("word_instr", instr_d, e.instr);
                    check("word_pc4", pc_plus4_d, e.pc + 32'd4);
                    check("word_op", {26'd0, op_d}, {26'd0, e.instr[31:26]});
                    check("word_funct", {26'd0, funct_d}, {26'd0, e.instr[5:0]});
                end
            end else begin
                check("bubble_instr", instr_d, NOP_INSTR);
            end
            if (exp_q.size() > 0) begin
                check("pc_f", pc_f, exp_q[0].pc);
                if (imem_if.req) begin
                    check("imem_addr", imem_if.addr, exp_q[0].pc);
                end
            end
            p_instr = instr_d;
            p_pc4   = pc_plus4_d;
            p_vld   = valid_d;
        end
    end

endmodule
